packet_transmitter: RTL
=======================

Name: packet_transmitter

Overview:
- Parametrised serial packet sender: header byte followed by NUM_BYTES payload bytes over one 8N1 UART line, least-significant payload byte first.
- Generalises the fixed 4-byte counter transmitter: runs in a single clock domain with an internal baud divider, configurable payload length and inter-byte gap, and a busy/done handshake.
- Sits between timestamp/counter producers and the board's serial output pin.

Parameters:
- NUM_BYTES, 4, payload length in bytes (1..16).
- CLKS_PER_BIT, 434, clk cycles per serial bit (434 = 115200 baud at 50 MHz); must be >= 2.
- GAP_BITS, 0, idle (mark) bit-times inserted between consecutive bytes; none after the last byte.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; a rising edge launches a packet.
- header  input  8  identification byte; sampled at launch.
- payload  input  8*NUM_BYTES  data; sampled at launch; byte k = payload[8k+7:8k].
- txd  output  1  serial line, idle high.
- busy  output  1  high from launch until the done pulse (inclusive).
- done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (async, active-high):
  - txd=1, busy=0, done=0.
  - FSM=IDLE; all counters cleared; start-edge history cleared.
  - Asserting rst mid-packet aborts immediately: txd returns high in the same cycle, with no partial stop bit. After release the block waits in IDLE for a fresh rising edge.
- Start detection:
  - start_q is registered every cycle; launch = start & ~start_q & (state==IDLE).
  - A level held high launches only once.
  - Edges while busy are ignored and not queued.
- FSM states: IDLE, LOAD, SHIFT, GAP, FINISH.
- IDLE -> LOAD on launch. On that edge, header and payload are copied into the shift buffer, byte_idx=0, and busy=1.
- LOAD:
  - Selects byte_idx (0 = header, k+1 = payload byte k) into the 10-bit frame {1,data,0}.
  - Resets the baud counter.
  - Goes to SHIFT.
- Timing: txd falls (start bit) on the second clock edge after the edge that sampled launch.
- SHIFT:
  - Emits 10 bits LSB first, each exactly CLKS_PER_BIT cycles.
  - After the stop bit: if the last byte was sent -> FINISH; else if GAP_BITS>0 -> GAP; else -> LOAD with byte_idx+1.
  - The LOAD cycle adds one idle cycle between frames; txd stays high during it.
- GAP: txd high for GAP_BITS*CLKS_PER_BIT cycles, then LOAD with byte_idx+1.
- FINISH: done=1 for one cycle, busy=0 on the next edge, then IDLE.
- Packet length (no checksum) = (NUM_BYTES+1)*(10*CLKS_PER_BIT+1) + NUM_BYTES*GAP_BITS*CLKS_PER_BIT cycles, measured from the LOAD entry to FINISH entry.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits.
  - byte_idx: $clog2(NUM_BYTES+2) bits.
  - Gap counter: wide enough for GAP_BITS*CLKS_PER_BIT.
  - No counter wraps during a legal packet.
- txd is registered (no glitches). Input changes after launch do not affect the packet in flight.

Optional Feature:
- Macro: PACKET_TRANSMITTER_CHECKSUM_EN.
- When defined:
  - One extra byte is sent after the last payload byte: the two's-complement of the 8-bit sum of header and all payload bytes, so that all transmitted bytes sum to 0 mod 256.
  - The sum is computed during transmission, not combinationally at launch.
  - The GAP rule applies before the checksum byte as well.
- When undefined: exactly NUM_BYTES+1 bytes are sent, and no checksum logic exists.

Decomposition:
- Shared package pt_pkg holds:
  - the FSM state enum;
  - UART frame constants (START_BIT=0, STOP_BIT=1, FRAME_BITS=10);
  - a checksum function.
- One sub-module, uart_tx_serializer:
  - Interface: load pulse, 8-bit data, CLKS_PER_BIT parameter, txd, frame_done pulse.
  - Owns the baud counter and the bit shift register.
  - The top-level keeps the packet FSM, the byte select and the gap timer.

Test Plan:
- NUM_BYTES=4, CLKS_PER_BIT=4, GAP_BITS=0; header=0xA5, payload=0x11223344; pulse start -> txd decodes A5,44,33,22,11; done pulses once; busy spans launch..done.
- Same configuration with checksum enabled -> sixth byte 0xB1; byte sum mod 256 = 0.
- GAP_BITS=1, CLKS_PER_BIT=4 -> txd high for 5 cycles between stop bit and next start bit (4 gap + 1 LOAD); none after the last byte.
- Hold start high for 500 cycles -> exactly one packet. Pulse start again while busy -> ignored. Pulse start after done -> second packet.
- Change payload to 0xFFFFFFFF one cycle after launch -> transmitted bytes unchanged from the sampled values.
- Assert rst during the 3rd byte -> txd=1, busy=0, done=0 in the same cycle. Release, then pulse start -> a complete, correct packet from the header onward.

Source files
------------

// File: rtl/pt_pkg.sv
// Shared definitions for packet_transmitter: packet FSM states, 8N1 frame
// constants and the checksum helper used by the optional checksum byte.
package pt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    FINISH
  } pt_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

  // Byte that brings the running 8-bit sum of a packet to zero.
  function automatic logic [7:0] pt_checksum(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: a load pulse captures one byte, txd replays the frame
// one cycle later from a registered output; frame_done flags the last stop cycle.
module uart_tx_serializer
  import pt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg;
  logic [BW-1:0]         baud_cnt;
  logic [3:0]            bit_cnt;
  logic                  active;

  // shreg[0] is the bit on the line next cycle; it refills with mark so idle stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      active     <= 1'b0;
      txd        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      txd        <= shreg[0];
      frame_done <= 1'b0;
      if (load) begin
        shreg    <= {STOP_BIT, data, START_BIT};
        baud_cnt <= '0;
        bit_cnt  <= '0;
        active   <= 1'b1;
      end else if (active) begin
        // Raised one cycle early so the packet FSM can react on the final stop cycle.
        if (bit_cnt == BIT_LAST && baud_cnt == BAUD_PRE) frame_done <= 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
          if (bit_cnt == BIT_LAST) active <= 1'b0;
          else bit_cnt <= bit_cnt + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/packet_transmitter.sv
// Header + NUM_BYTES payload bytes (LSB byte first) over one 8N1 line.
// Define PACKET_TRANSMITTER_CHECKSUM_EN to append a zero-sum checksum byte.
module packet_transmitter
  import pt_pkg::*;
#(
  parameter int NUM_BYTES    = 4,
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_BITS     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             header,
  input  logic [8*NUM_BYTES-1:0] payload,
  output logic                   txd,
  output logic                   busy,
  output logic                   done
);

`ifdef PACKET_TRANSMITTER_CHECKSUM_EN
  localparam int LAST_IDX = NUM_BYTES + 1;
`else
  localparam int LAST_IDX = NUM_BYTES;
`endif
  localparam int IDX_W   = $clog2(NUM_BYTES + 2);
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  pt_state_e                  state;
  logic                       start_q;
  logic [IDX_W-1:0]           byte_idx;
  logic [GW-1:0]              gap_cnt;
  logic [8*(NUM_BYTES+1)-1:0] pkt_buf;
  logic [7:0]                 cur_byte;
  logic                       launch;
  logic                       load;
  logic                       frame_done;

  // Handshake: start is a rising-edge request honoured only in IDLE (edges while
  // busy are dropped); busy spans launch through the done pulse, done lasts one cycle.
  assign launch = start & ~start_q & (state == IDLE);
  assign load   = (state == LOAD);

`ifdef PACKET_TRANSMITTER_CHECKSUM_EN
  logic [7:0] sum_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_acc <= '0;
    else if (launch) sum_acc <= '0;
    else if (load) sum_acc <= sum_acc + cur_byte;
  end
`endif

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k <= NUM_BYTES; k++) begin
      if (byte_idx == IDX_W'(k)) cur_byte = pkt_buf[8*k +: 8];
    end
`ifdef PACKET_TRANSMITTER_CHECKSUM_EN
    if (byte_idx == IDX_W'(LAST_IDX)) cur_byte = pt_checksum(sum_acc);
`endif
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (cur_byte),
    .txd       (txd),
    .frame_done(frame_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      pkt_buf  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (launch) begin
            pkt_buf  <= {payload, header};
            byte_idx <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          if (frame_done) begin
            if (byte_idx == IDX_W'(LAST_IDX)) begin
              state <= FINISH;
            end else if (GAP_BITS > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            byte_idx <= byte_idx + 1'b1;
            state    <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
